// File: rtl/mac_tx_ctrl.sv
// mac_tx_ctrl: client-to-MAC transmit controller.
// Buffers client beats tagged {dval,sop,eop} plus mod in a small FIFO. Stray
// beats outside a frame are dropped, and a sop inside an open frame closes that
// frame as corrupt. The controller drives the MAC ff_tx_* interface through one
// output register stage and honours ff_tx_rdy backpressure.
// Optional build macro MAC_TX_PAD_EN: frames shorter than MIN_FRAME bytes are
// zero-padded on the way out.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   client_txd                 client beat data
//   client_tx_valid            {dval, sop, eop}
//   client_tx_mod              invalid byte count on the eop beat
//   client_tx_ready            buffer can accept a beat
//   ff_tx_clk                  copy of clk for the MAC
//   ff_tx_data/sop/eop/wren    MAC beat and its framing
//   ff_tx_mod/err              eop-qualified invalid bytes and corrupt flag
//   ff_tx_crc_fwd              tied low, so the MAC appends the CRC
//   ff_tx_rdy                  MAC takes the beat when wren and rdy are both high
//   drop_cnt                   saturating count of dropped beats and aborted frames
module mac_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MIN_FRAME  = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] client_txd,
  input  logic [2:0]            client_tx_valid,
  input  logic [1:0]            client_tx_mod,
  output logic                  client_tx_ready,
  output logic                  ff_tx_clk,
  output logic [DATA_WIDTH-1:0] ff_tx_data,
  output logic                  ff_tx_sop,
  output logic                  ff_tx_eop,
  output logic                  ff_tx_wren,
  output logic [1:0]            ff_tx_mod,
  output logic                  ff_tx_err,
  output logic                  ff_tx_crc_fwd,
  input  logic                  ff_tx_rdy,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [1:0]            mod;
    logic                  err;
  } entry_t;

  typedef enum logic {W_IDLE, W_FRAME} wstate_e;

  // Reject illegal configurations at elaboration.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 32) || FIFO_DEPTH < 4 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (MIN_FRAME % (DATA_WIDTH / 8)) != 0) begin : g_bad_cfg
    $error("mac_tx_ctrl: illegal parameter combination");
  end

  logic          in_dval, in_sop, in_eop, acc;
  wstate_e       wst_q;
  logic          wr_en, drop_evt;
  entry_t        wr_entry;
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, empty, pop, load;
  entry_t        rd_entry, nxt, out_q;
  logic          nxt_vld, vld_q;
  logic [15:0]   drop_q;

  assign {in_dval, in_sop, in_eop} = client_tx_valid;
  assign acc = in_dval & ready_q;

  // Framing decode of the accepted beat into a FIFO write.
  always_comb begin
    wr_en         = 1'b0;
    drop_evt      = 1'b0;
    wr_entry      = '0;
    wr_entry.data = client_txd;
    if (acc) begin
      if (wst_q == W_IDLE) begin
        if (in_sop) begin
          wr_en        = 1'b1;
          wr_entry.sop = 1'b1;
          wr_entry.eop = in_eop;
          wr_entry.mod = in_eop ? client_tx_mod : 2'b00;
        end else begin
          drop_evt = 1'b1;
        end
      end else if (in_sop) begin
        // Abort: this beat closes the open frame as corrupt; its own frame is lost.
        wr_en        = 1'b1;
        wr_entry.eop = 1'b1;
        wr_entry.err = 1'b1;
        drop_evt     = 1'b1;
      end else begin
        wr_en        = 1'b1;
        wr_entry.eop = in_eop;
        wr_entry.mod = in_eop ? client_tx_mod : 2'b00;
      end
    end
  end

  // Write FSM: tracks whether a client frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q <= W_IDLE;
    end else if (acc) begin
      case (wst_q)
        W_IDLE:  if (in_sop && !in_eop) wst_q <= W_FRAME;
        W_FRAME: if (in_sop || in_eop) wst_q <= W_IDLE;
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // Beat storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign load     = ~vld_q | ff_tx_rdy;
  assign count_d  = count_q + CW'(wr_en) - CW'(pop);

  // Pointers and occupancy; ready comes from next-state occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CW'(FIFO_DEPTH));
    end
  end

  // Saturating drop/abort counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_evt && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

`ifdef MAC_TX_PAD_EN
  localparam int unsigned W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAD} rstate_e;

  rstate_e     rs_q, rs_d;
  logic [15:0] bytes_q, bytes_d, base, frame_bytes;
  logic        pad_err_q, pad_err_d;

  // Read side with short-frame padding; the FIFO is not read while padding.
  always_comb begin
    rs_d        = rs_q;
    bytes_d     = bytes_q;
    pad_err_d   = pad_err_q;
    pop         = 1'b0;
    nxt_vld     = 1'b0;
    nxt         = '0;
    base        = rd_entry.sop ? 16'd0 : bytes_q;
    // Counting stops once MIN_FRAME is reached, so long frames cannot wrap it.
    frame_bytes = (base >= 16'(MIN_FRAME)) ? base : base + 16'(W) - 16'(rd_entry.mod);
    if (load) begin
      if (rs_q == R_PAD) begin
        nxt_vld = 1'b1;
        bytes_d = bytes_q + 16'(W);
        if (bytes_d >= 16'(MIN_FRAME)) begin
          nxt.eop = 1'b1;
          nxt.err = pad_err_q;
          rs_d    = R_IDLE;
        end
      end else if (!empty) begin
        pop     = 1'b1;
        nxt_vld = 1'b1;
        nxt     = rd_entry;
        bytes_d = frame_bytes;
        rs_d    = R_DATA;
        if (rd_entry.eop) begin
          rs_d = R_IDLE;
          if (!rd_entry.err && frame_bytes < 16'(MIN_FRAME)) begin
            // Invalid tail bytes become zero pad, so the beat now counts as W bytes.
            nxt.eop = 1'b0;
            nxt.mod = 2'b00;
            for (int unsigned b = 0; b < W; b++) begin
              if (b < 32'(rd_entry.mod)) nxt.data[b*8 +: 8] = 8'h00;
            end
            bytes_d   = base + 16'(W);
            pad_err_d = rd_entry.err;
            rs_d      = R_PAD;
          end
        end
      end
    end
  end

  // Read FSM state and byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q      <= R_IDLE;
      bytes_q   <= '0;
      pad_err_q <= 1'b0;
    end else begin
      rs_q      <= rs_d;
      bytes_q   <= bytes_d;
      pad_err_q <= pad_err_d;
    end
  end
`else
  // Read side: frames pass through unmodified.
  always_comb begin
    pop     = load & ~empty;
    nxt_vld = pop;
    nxt     = pop ? rd_entry : '0;
  end
`endif

  // Output register stage; holds while the MAC stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      out_q <= '0;
    end else if (load) begin
      vld_q <= nxt_vld;
      out_q <= nxt;
    end
  end

  assign client_tx_ready = ready_q;
  assign ff_tx_clk       = clk;
  assign ff_tx_data      = out_q.data;
  assign ff_tx_sop       = out_q.sop;
  assign ff_tx_eop       = out_q.eop;
  assign ff_tx_mod       = out_q.mod;
  assign ff_tx_err       = out_q.err;
  assign ff_tx_wren      = vld_q;
  assign ff_tx_crc_fwd   = 1'b0;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_mac_tx_ctrl.sv
`timescale 1ns/1ps
module tb_mac_tx_ctrl;

`ifdef MAC_TX_PAD_EN
  localparam int unsigned MIN_SMALL = 4;
`else
  localparam int unsigned MIN_SMALL = 60;
`endif
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic [7:0]  d8_txd;  logic [2:0] d8_valid; logic [1:0] d8_mod; logic c8_ready;
  logic        f8_clk;  logic [7:0] f8_data;  logic f8_sop, f8_eop, f8_wren, f8_err, f8_crc, rdy8;
  logic [1:0]  f8_mod;  logic [15:0] drop8;
  mac_tx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .MIN_FRAME(MIN_SMALL)) u8 (
    .clk(clk), .rst_n(rst_n), .client_txd(d8_txd), .client_tx_valid(d8_valid),
    .client_tx_mod(d8_mod), .client_tx_ready(c8_ready), .ff_tx_clk(f8_clk),
    .ff_tx_data(f8_data), .ff_tx_sop(f8_sop), .ff_tx_eop(f8_eop), .ff_tx_wren(f8_wren),
    .ff_tx_mod(f8_mod), .ff_tx_err(f8_err), .ff_tx_crc_fwd(f8_crc), .ff_tx_rdy(rdy8),
    .drop_cnt(drop8));

  // 32-bit instance
  logic [31:0] d32_txd; logic [2:0] d32_valid; logic [1:0] d32_mod; logic c32_ready;
  logic        f32_clk; logic [31:0] f32_data; logic f32_sop, f32_eop, f32_wren, f32_err, f32_crc, rdy32;
  logic [1:0]  f32_mod; logic [15:0] drop32;
  mac_tx_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .MIN_FRAME(MIN_SMALL)) u32 (
    .clk(clk), .rst_n(rst_n), .client_txd(d32_txd), .client_tx_valid(d32_valid),
    .client_tx_mod(d32_mod), .client_tx_ready(c32_ready), .ff_tx_clk(f32_clk),
    .ff_tx_data(f32_data), .ff_tx_sop(f32_sop), .ff_tx_eop(f32_eop), .ff_tx_wren(f32_wren),
    .ff_tx_mod(f32_mod), .ff_tx_err(f32_err), .ff_tx_crc_fwd(f32_crc), .ff_tx_rdy(rdy32),
    .drop_cnt(drop32));

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
    int          cyc;
  } beat_t;

  beat_t mon8[$];
  beat_t mon32[$];
  beat_t b8, b32;

  always @(negedge clk) begin
    if (f8_wren && rdy8) begin
      b8.data = 32'(f8_data); b8.sop = f8_sop; b8.eop = f8_eop;
      b8.mod = f8_mod; b8.err = f8_err; b8.cyc = cyc;
      mon8.push_back(b8);
    end
    if (f32_wren && rdy32) begin
      b32.data = f32_data; b32.sop = f32_sop; b32.eop = f32_eop;
      b32.mod = f32_mod; b32.err = f32_err; b32.cyc = cyc;
      mon32.push_back(b32);
    end
  end

`ifdef MAC_TX_PAD_EN
  // Padding instance at the real minimum frame size
  logic [7:0]  dp_txd;  logic [2:0] dp_valid; logic [1:0] dp_mod; logic cp_ready;
  logic        fp_clk;  logic [7:0] fp_data;  logic fp_sop, fp_eop, fp_wren, fp_err, fp_crc, rdyp;
  logic [1:0]  fp_mod;  logic [15:0] dropp;
  beat_t monp[$];
  beat_t bp;
  mac_tx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .MIN_FRAME(60)) up (
    .clk(clk), .rst_n(rst_n), .client_txd(dp_txd), .client_tx_valid(dp_valid),
    .client_tx_mod(dp_mod), .client_tx_ready(cp_ready), .ff_tx_clk(fp_clk),
    .ff_tx_data(fp_data), .ff_tx_sop(fp_sop), .ff_tx_eop(fp_eop), .ff_tx_wren(fp_wren),
    .ff_tx_mod(fp_mod), .ff_tx_err(fp_err), .ff_tx_crc_fwd(fp_crc), .ff_tx_rdy(rdyp),
    .drop_cnt(dropp));

  always @(negedge clk) begin
    if (fp_wren && rdyp) begin
      bp.data = 32'(fp_data); bp.sop = fp_sop; bp.eop = fp_eop;
      bp.mod = fp_mod; bp.err = fp_err; bp.cyc = cyc;
      monp.push_back(bp);
    end
  end

  task automatic putp(input logic [7:0] d, input logic [2:0] v);
    int n;
    n = 0;
    dp_txd = d; dp_valid = v; dp_mod = 2'b00;
    while (cp_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL putp_timeout: ready=%b want 1", cp_ready); end
    @(posedge clk); #1;
    dp_valid = 3'b000;
  endtask

  task automatic test_pad();
    int n;
    monp.delete(); rdyp = 1'b1;
    for (int i = 0; i < 10; i++) putp(8'(i + 1), {1'b1, i == 0, i == 9});
    n = 0;
    while (monp.size() < 60 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (5) begin @(posedge clk); #1; end
    total++; if (monp.size() != 60) begin bad++; $display("FAIL pad_count: got %0d want 60", monp.size()); end
    for (int i = 0; i < monp.size(); i++) begin
      total++;
      if (monp[i].data !== ((i < 10) ? 32'(i + 1) : 32'd0) || monp[i].eop !== (i == 59) ||
          monp[i].sop !== (i == 0) || monp[i].mod !== 2'b00 || monp[i].err !== 1'b0) begin
        bad++; $display("FAIL pad_beat%0d: got data=%0h sop=%b eop=%b mod=%0d err=%b",
                        i, monp[i].data, monp[i].sop, monp[i].eop, monp[i].mod, monp[i].err);
      end
    end
    total++; if (fp_crc !== 1'b0 || dropp !== 16'd0) begin bad++; $display("FAIL pad_misc: crc=%b drop=%0d want 0 0", fp_crc, dropp); end
  endtask
`endif

  task automatic put8(input logic [7:0] d, input logic [2:0] v, input logic [1:0] m);
    int n;
    n = 0;
    d8_txd = d; d8_valid = v; d8_mod = m;
    while (c8_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL put8_timeout: ready=%b want 1", c8_ready); end
    @(posedge clk); #1;
    d8_valid = 3'b000; d8_mod = 2'b00;
  endtask

  task automatic put32(input logic [31:0] d, input logic [2:0] v, input logic [1:0] m);
    int n;
    n = 0;
    d32_txd = d; d32_valid = v; d32_mod = m;
    while (c32_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL put32_timeout: ready=%b want 1", c32_ready); end
    @(posedge clk); #1;
    d32_valid = 3'b000; d32_mod = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (f8_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", f8_wren); end
    total++; if (f8_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", f8_data); end
    total++; if ({f8_sop, f8_eop, f8_mod, f8_err} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {f8_sop, f8_eop, f8_mod, f8_err}); end
    total++; if (drop8 !== 16'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop8); end
    total++; if (f8_crc !== 1'b0 || f32_crc !== 1'b0) begin bad++; $display("FAIL reset_crc_fwd: got %b%b want 00", f8_crc, f32_crc); end
    total++; if (f8_clk !== clk || f32_clk !== clk) begin bad++; $display("FAIL reset_ff_clk: got %b%b want %b", f8_clk, f32_clk, clk); end
    total++; if (f32_wren !== 1'b0 || drop32 !== 16'd0) begin bad++; $display("FAIL reset_u32: wren=%b drop=%0d want 0 0", f32_wren, drop32); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (c8_ready !== 1'b1 || c32_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b%b want 11", c8_ready, c32_ready); end
  endtask

  task automatic test_back_to_back();
    int t0, n;
    mon8.delete(); rdy8 = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 64; i++) put8(8'(i), {1'b1, i == 0, i == 63}, 2'b00);
    n = 0;
    while (mon8.size() < 64 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (mon8.size() != 64) begin bad++; $display("FAIL b2b_count: got %0d want 64", mon8.size()); end
    if (mon8.size() > 0) begin
      total++; if (mon8[0].cyc != t0 + 2) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", mon8[0].cyc - t0, 2); end
      total++; if (mon8[mon8.size()-1].cyc - mon8[0].cyc != mon8.size() - 1) begin bad++; $display("FAIL b2b_gapless: span %0d want %0d", mon8[mon8.size()-1].cyc - mon8[0].cyc, mon8.size() - 1); end
    end
    for (int i = 0; i < mon8.size(); i++) begin
      total++;
      if (mon8[i].data !== 32'(i) || mon8[i].sop !== (i == 0) || mon8[i].eop !== (i == 63) ||
          mon8[i].mod !== 2'b00 || mon8[i].err !== 1'b0) begin
        bad++; $display("FAIL b2b_beat%0d: got data=%0h sop=%b eop=%b mod=%0d err=%b",
                        i, mon8[i].data, mon8[i].sop, mon8[i].eop, mon8[i].mod, mon8[i].err);
      end
    end
    total++; if (drop8 !== 16'd0) begin bad++; $display("FAIL b2b_drop: got %0d want 0", drop8); end
  endtask

  task automatic test_backpressure();
    int n_acc, fall_at, n;
    logic [13:0] snap;
    mon8.delete(); rdy8 = 1'b1;
    for (int i = 0; i < 4; i++) put8(8'(i), {1'b1, i == 0, 1'b0}, 2'b00);
    repeat (5) begin @(posedge clk); #1; end
    total++; if (f8_wren !== 1'b0) begin bad++; $display("FAIL bp_drained: wren=%b want 0", f8_wren); end
    rdy8 = 1'b0; n_acc = 0; fall_at = -1; snap = '0;
    for (int i = 0; i < 20; i++) begin
      if (c8_ready === 1'b1) begin
        d8_txd = 8'(4 + n_acc); d8_valid = 3'b100; n_acc++;
      end else begin
        d8_valid = 3'b000;
        if (fall_at < 0) fall_at = n_acc;
      end
      @(negedge clk);
      if (i == 2) begin
        snap = {f8_wren, f8_data, f8_sop, f8_eop, f8_mod, f8_err};
        total++; if (snap !== {1'b1, 8'h04, 5'b0}) begin bad++; $display("FAIL bp_stalled_beat: got %h want %h", snap, {1'b1, 8'h04, 5'b0}); end
      end else if (i > 2) begin
        total++;
        if ({f8_wren, f8_data, f8_sop, f8_eop, f8_mod, f8_err} !== snap) begin
          bad++; $display("FAIL bp_hold_c%0d: got %h want %h", i, {f8_wren, f8_data, f8_sop, f8_eop, f8_mod, f8_err}, snap);
        end
      end
      @(posedge clk); #1;
    end
    d8_valid = 3'b000;
    total++; if (fall_at != int'(DEPTH) + 1) begin bad++; $display("FAIL bp_ready_fall: after %0d accepts want %0d", fall_at, DEPTH + 1); end
    rdy8 = 1'b1;
    for (int i = 4 + n_acc; i < 30; i++) put8(8'(i), {1'b1, 1'b0, i == 29}, 2'b00);
    n = 0;
    while (mon8.size() < 30 && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    total++; if (mon8.size() != 30) begin bad++; $display("FAIL bp_count: got %0d want 30", mon8.size()); end
    for (int i = 0; i < mon8.size(); i++) begin
      total++;
      if (mon8[i].data !== 32'(i) || mon8[i].sop !== (i == 0) || mon8[i].eop !== (i == 29)) begin
        bad++; $display("FAIL bp_beat%0d: got data=%0h sop=%b eop=%b", i, mon8[i].data, mon8[i].sop, mon8[i].eop);
      end
    end
  endtask

  task automatic test_framing();
    int n;
    mon8.delete(); rdy8 = 1'b1;
    put8(8'hAA, 3'b100, 2'b00);
    repeat (3) begin @(posedge clk); #1; end
    total++; if (drop8 !== 16'd1) begin bad++; $display("FAIL frm_stray_drop: got %0d want 1", drop8); end
    total++; if (mon8.size() != 0) begin bad++; $display("FAIL frm_stray_sent: got %0d beats want 0", mon8.size()); end
    put8(8'h10, 3'b110, 2'b00);
    put8(8'h11, 3'b100, 2'b00);
    put8(8'h12, 3'b110, 2'b00);
    n = 0;
    while (mon8.size() < 3 && n < 30) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (mon8.size() != 3) begin bad++; $display("FAIL frm_count: got %0d want 3", mon8.size()); end
    if (mon8.size() == 3) begin
      total++; if ({mon8[0].data[7:0], mon8[0].sop, mon8[0].eop, mon8[0].err} !== {8'h10, 3'b100}) begin bad++; $display("FAIL frm_first: got data=%0h sop=%b eop=%b err=%b", mon8[0].data, mon8[0].sop, mon8[0].eop, mon8[0].err); end
      total++; if ({mon8[1].data[7:0], mon8[1].sop, mon8[1].eop} !== {8'h11, 2'b00}) begin bad++; $display("FAIL frm_mid: got data=%0h sop=%b eop=%b", mon8[1].data, mon8[1].sop, mon8[1].eop); end
      total++; if ({mon8[2].data[7:0], mon8[2].eop, mon8[2].err, mon8[2].mod} !== {8'h12, 2'b11, 2'b00}) begin bad++; $display("FAIL frm_abort: got data=%0h eop=%b err=%b mod=%0d want 12 1 1 0", mon8[2].data, mon8[2].eop, mon8[2].err, mon8[2].mod); end
    end
    total++; if (drop8 !== 16'd2) begin bad++; $display("FAIL frm_abort_drop: got %0d want 2", drop8); end
    put8(8'h13, 3'b101, 2'b00);
    repeat (3) begin @(posedge clk); #1; end
    total++; if (drop8 !== 16'd3 || mon8.size() != 3) begin bad++; $display("FAIL frm_lost_tail: drop=%0d beats=%0d want 3 3", drop8, mon8.size()); end
  endtask

  task automatic test_mod32();
    int n;
    logic [31:0] ed [3];
    logic [1:0]  em [3];
    ed[0] = 32'h03020100; ed[1] = 32'h07060504; ed[2] = 32'h0B0A0908;
    em[0] = 2'd0; em[1] = 2'd0; em[2] = 2'd2;
    mon32.delete(); rdy32 = 1'b1;
    put32(ed[0], 3'b110, 2'b00);
    put32(ed[1], 3'b100, 2'b10);
    put32(ed[2], 3'b101, 2'b10);
    n = 0;
    while (mon32.size() < 3 && n < 30) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (mon32.size() != 3) begin bad++; $display("FAIL m32_count: got %0d want 3", mon32.size()); end
    for (int i = 0; i < mon32.size() && i < 3; i++) begin
      total++;
      if (mon32[i].data !== ed[i] || mon32[i].mod !== em[i] || mon32[i].sop !== (i == 0) ||
          mon32[i].eop !== (i == 2) || mon32[i].err !== 1'b0) begin
        bad++; $display("FAIL m32_beat%0d: got data=%0h mod=%0d sop=%b eop=%b want data=%0h mod=%0d",
                        i, mon32[i].data, mon32[i].mod, mon32[i].sop, mon32[i].eop, ed[i], em[i]);
      end
    end
    total++; if (drop32 !== 16'd0) begin bad++; $display("FAIL m32_drop: got %0d want 0", drop32); end
  endtask

  task automatic test_reset_midframe();
    int n;
    mon8.delete(); rdy8 = 1'b0;
    put8(8'h40, 3'b110, 2'b00);
    put8(8'h41, 3'b100, 2'b00);
    put8(8'h42, 3'b100, 2'b00);
    total++; if (f8_wren !== 1'b1) begin bad++; $display("FAIL rm_buffered: wren=%b want 1", f8_wren); end
    rst_n = 1'b0;
    #1;
    total++; if (f8_wren !== 1'b0) begin bad++; $display("FAIL rm_wren_async: got %b want 0", f8_wren); end
    total++; if (drop8 !== 16'd0) begin bad++; $display("FAIL rm_drop_clear: got %0d want 0", drop8); end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; rdy8 = 1'b1;
    @(posedge clk); #1;
    total++; if (c8_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", c8_ready); end
    for (int i = 0; i < 4; i++) put8(8'(8'h50 + i), {1'b1, i == 0, i == 3}, 2'b00);
    n = 0;
    while (mon8.size() < 4 && n < 30) begin @(posedge clk); #1; n++; end
    repeat (5) begin @(posedge clk); #1; end
    total++; if (mon8.size() != 4) begin bad++; $display("FAIL rm_count: got %0d want 4", mon8.size()); end
    for (int i = 0; i < mon8.size(); i++) begin
      total++;
      if (mon8[i].data !== 32'(8'h50 + i) || mon8[i].sop !== (i == 0) || mon8[i].eop !== (i == 3) || mon8[i].err !== 1'b0) begin
        bad++; $display("FAIL rm_beat%0d: got data=%0h sop=%b eop=%b err=%b", i, mon8[i].data, mon8[i].sop, mon8[i].eop, mon8[i].err);
      end
    end
    total++; if (drop8 !== 16'd0) begin bad++; $display("FAIL rm_drop: got %0d want 0", drop8); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    d8_txd = '0;  d8_valid = '0;  d8_mod = '0;  rdy8 = 1'b1;
    d32_txd = '0; d32_valid = '0; d32_mod = '0; rdy32 = 1'b1;
`ifdef MAC_TX_PAD_EN
    dp_txd = '0;  dp_valid = '0;  dp_mod = '0;  rdyp = 1'b1;
`endif
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_mod32();
    test_reset_midframe();
`ifdef MAC_TX_PAD_EN
    test_pad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_tx_ctrl.md
Name: mac_tx_ctrl

Overview:
Client-to-MAC transmit controller; the transmit-direction counterpart of the receive controller on the same FIFO-style MAC interface. Accepts client beats tagged {dval,sop,eop} plus mod, and buffers them in a small FIFO. Enforces frame framing, drops malformed beats, and drives the MAC ff_tx_* interface with ff_tx_rdy backpressure. Sits between the NIC transmit datapath and the MAC core.

Parameters:
DATA_WIDTH, 8, beat width in bits; legal values are 8 and 32 (W = DATA_WIDTH/8 bytes per beat).
FIFO_DEPTH, 8, number of entries in the beat buffer; power of 2, at least 4.
MIN_FRAME, 60, minimum frame length in bytes excluding CRC (used only with padding); must be a multiple of W.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
client_txd  in  DATA_WIDTH  client beat data
client_tx_valid  in  3  {dval, sop, eop}
client_tx_mod  in  2  count of invalid bytes on the eop beat; must be 0 when DATA_WIDTH=8
client_tx_ready  out  1  buffer can accept a beat
ff_tx_clk  out  1  equals clk
ff_tx_data  out  DATA_WIDTH  MAC beat data
ff_tx_sop  out  1  start of packet
ff_tx_eop  out  1  end of packet
ff_tx_wren  out  1  beat valid
ff_tx_mod  out  2  invalid bytes on the eop beat
ff_tx_err  out  1  frame is corrupt; qualified by eop
ff_tx_crc_fwd  out  1  tied to 0 (MAC appends CRC)
ff_tx_rdy  in  1  MAC accepts the beat when wren=1 and rdy=1
drop_cnt  out  16  saturating count of dropped or aborted events

Behaviour:
- Reset values: ff_tx_data=0, sop=0, eop=0, wren=0, mod=0, err=0, drop_cnt=0. FIFO is empty and both FSMs are in their idle state. client_tx_ready=1 one cycle after reset deasserts.
- client_tx_ready = !fifo_full; it is registered from the next-state occupancy, so there is no combinational path from the client inputs.
- Accept condition: a beat is accepted when dval=1 and client_tx_ready=1. Beats offered while ready=0 are lost and are not counted; the client must hold them.
- Write FSM states: W_IDLE and W_FRAME.
  - In W_IDLE, a beat with sop is stored. If that beat also has eop, the FSM stays in W_IDLE; otherwise it moves to W_FRAME.
  - In W_IDLE, a beat without sop is discarded and drop_cnt increments.
  - In W_FRAME, a beat without sop is stored, and the FSM returns to W_IDLE if the beat has eop.
  - In W_FRAME, a beat with sop is an abort. The beat is stored with eop forced to 1, err=1 and mod=0. The FSM goes to W_IDLE, drop_cnt increments, and the new frame is lost.
- FIFO entry: {data, sop, eop, mod, err}. Write and read in the same cycle is legal at any occupancy, including full; occupancy is then unchanged.
- Output stage: one register stage between FIFO and MAC.
  - The stage loads from the FIFO when it is empty, or when wren & rdy.
  - While wren=1 and rdy=0, all ff_tx_* outputs hold stable.
- Latency: 2 cycles from client accept to ff_tx_wren, with an empty FIFO and rdy=1.
- Throughput: one beat per cycle while rdy stays high.
- drop_cnt saturates at 0xFFFF.
- ff_tx_mod and ff_tx_err are driven only on the eop beat and are 0 on all other beats.

Optional Feature:
Macro: MAC_TX_PAD_EN.
- When defined, a read-side FSM with states R_IDLE, R_DATA and R_PAD counts bytes per frame: W per beat, minus mod on the eop beat.
- If eop arrives with a byte count below MIN_FRAME:
  - The eop beat is sent with eop=0.
  - Its mod low-order invalid bytes are forced to 0.
  - The FSM enters R_PAD and emits all-zero beats until MIN_FRAME bytes have been sent.
  - The final pad beat carries eop=1, mod=0, and the err value of the original eop beat.
  - FIFO reads stall during R_PAD.
- An aborted frame (err=1) is never padded.
- When the macro is undefined, frames pass unmodified, and the byte counter and R_PAD logic are absent.

Test Plan:
- Back-to-back frame, DATA_WIDTH=8: 64-beat frame (sop on beat 0, eop on beat 63, data = incrementing bytes), rdy=1 throughout -> 64 consecutive wren beats starting 2 cycles after the first accept, sop/eop on the correct beats, drop_cnt=0.
- Backpressure: rdy held low for 20 cycles mid-frame -> ff_tx_* stable throughout; client_tx_ready falls after FIFO_DEPTH+1 accepts; no beat lost or duplicated.
- Framing errors: dval beat without sop while idle -> dropped, drop_cnt=1. Then a sop beat inside an open frame -> that beat is sent with eop=1 and err=1, drop_cnt=2.
- DATA_WIDTH=32, 3-beat frame with mod=2 on eop -> ff_tx_mod=2 on the eop beat only.
- MAC_TX_PAD_EN, DATA_WIDTH=8: 10-byte frame -> 60 beats out; beats 10..59 are 0x00 and eop is on beat 59.
- Reset mid-frame: assert rst_n low with 3 beats buffered -> wren=0 and FIFO empty immediately; next frame transmits cleanly.
